// File: rtl/alu_muldiv_pkg.sv
// rtl/alu_muldiv_pkg.sv - opcode and state encodings shared by the ALU/mul-div unit
package alu_muldiv_pkg;

    localparam int OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_NOR  = 4'd5,
        OP_SLT  = 4'd6,
        OP_SLTU = 4'd7,
        OP_SLL  = 4'd8,
        OP_SRL  = 4'd9,
        OP_SRA  = 4'd10,
        OP_MULU = 4'd11,
        OP_DIVU = 4'd12,
        OP_MFHI = 4'd13,
        OP_MFLO = 4'd14,
        OP_RSVD = 4'd15
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_e;

endpackage

// File: rtl/alu_muldiv_if.sv
// rtl/alu_muldiv_if.sv - request/response handshake bundle between EX stage and the ALU
interface alu_muldiv_if #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [SEL_W-1:0] op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] c;
    logic             c_out;
    logic             overflow;
    logic             zero;
    logic             div_zero;
    logic             busy;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, c, c_out, overflow, zero, div_zero, busy
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, c, c_out, overflow, zero, div_zero, busy
    );
endinterface

// File: rtl/alu_muldiv_muldiv_iter.sv
// rtl/alu_muldiv_muldiv_iter.sv - iterative shift-add multiplier / restoring divider
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CNT_W = $clog2(WIDTH);

    // hi_q: partial product high half / running remainder
    // lo_q: multiplier shifting out / dividend shifting into quotient
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;
    logic             div_q, div_d;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_diff;

    // One iteration per cycle; the final iteration's result is presented
    // combinationally alongside done so the owner can commit on that edge.
    always_comb begin
        hi_d     = hi_q;
        lo_d     = lo_q;
        m_d      = m_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        div_d    = div_q;
        done     = 1'b0;
        add_sum  = lo_q[0] ? ({1'b0, hi_q} + {1'b0, m_q}) : {1'b0, hi_q};
        rem_sh   = {hi_q, lo_q[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, m_q};
        if (start) begin
            hi_d  = '0;
            lo_d  = a;
            m_d   = b;
            div_d = is_div;
            cnt_d = '0;
            run_d = 1'b1;
        end else if (run_q) begin
            if (div_q) begin
                // rem_diff[WIDTH] set means the trial subtraction borrowed
                if (!rem_diff[WIDTH]) begin
                    hi_d = rem_diff[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    hi_d = rem_sh[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                {hi_d, lo_d} = {add_sum, lo_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
                run_d = 1'b0;
                done  = 1'b1;
            end
        end
    end

    // Iteration registers; reset abandons any operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q  <= '0;
            lo_q  <= '0;
            m_q   <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
            div_q <= 1'b0;
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            m_q   <= m_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
            div_q <= div_d;
        end
    end

    assign hi = hi_d;
    assign lo = lo_d;

endmodule

// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - EX-stage ALU with registered single-cycle ops and iterative MULU/DIVU
module alu_muldiv
    import alu_muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SEL_W = 4
) (
    input logic         clk,
    input logic         rst,
    alu_muldiv_if.slave bus
);
    localparam int SH_W = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] hi_q, lo_q, c_q;
    logic             c_out_q, overflow_q, zero_q, div_zero_q, out_valid_q;
    logic             in_ready, busy;
    logic             accept, start_iter, div_by_zero;
    logic             iter_done;
    logic [WIDTH-1:0] eng_hi, eng_lo;
    op_e              op_c;
    logic [SH_W-1:0]  shamt;
    logic [WIDTH:0]   add_ext, sub_ext;
    logic [WIDTH-1:0] res_c;
    logic             res_cout, res_ovf, res_dz;

    assign op_c        = op_e'(bus.op[OP_W-1:0]);
    assign shamt       = bus.b[SH_W-1:0];
    assign div_by_zero = (op_c == OP_DIVU) && (bus.b == '0);
    assign accept      = bus.in_valid && in_ready;
    assign start_iter  = accept && ((op_c == OP_MULU) || ((op_c == OP_DIVU) && !div_by_zero));

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .rst    (rst),
        .start  (start_iter),
        .is_div (op_c == OP_DIVU),
        .a      (bus.a),
        .b      (bus.b),
        .done   (iter_done),
        .hi     (eng_hi),
        .lo     (eng_lo)
    );

    // Control state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Enter MUL/DIV on an iterative accept, return to IDLE when the engine finishes
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_iter) state_d = (op_c == OP_MULU) ? ST_MUL : ST_DIV;
            ST_MUL,
            ST_DIV:  if (iter_done) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs: a pending unconsumed result blocks new work
    always_comb begin
        in_ready = !rst && (state_q == ST_IDLE) && !(out_valid_q && !bus.out_ready);
        busy     = (state_q != ST_IDLE);
    end

    // Single-cycle datapath, evaluated on the operands being accepted
    always_comb begin
        add_ext  = {1'b0, bus.a} + {1'b0, bus.b};
        sub_ext  = {1'b0, bus.a} + {1'b0, ~bus.b} + (WIDTH+1)'(1);
        res_c    = '0;
        res_cout = 1'b0;
        res_ovf  = 1'b0;
        res_dz   = 1'b0;
        case (op_c)
            OP_ADD: begin
                res_c    = add_ext[WIDTH-1:0];
                res_cout = add_ext[WIDTH];
                res_ovf  = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (add_ext[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                res_c    = sub_ext[WIDTH-1:0];
                res_cout = sub_ext[WIDTH];
                res_ovf  = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (sub_ext[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_AND:  res_c = bus.a & bus.b;
            OP_OR:   res_c = bus.a | bus.b;
            OP_XOR:  res_c = bus.a ^ bus.b;
            OP_NOR:  res_c = ~(bus.a | bus.b);
            OP_SLT:  res_c = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_SLTU: res_c = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            OP_SLL:  res_c = bus.a << shamt;
            OP_SRL:  res_c = bus.a >> shamt;
            OP_SRA:  res_c = $signed(bus.a) >>> shamt;
            OP_DIVU: begin
                // only reaches this path when the divisor is zero
                res_c  = '1;
                res_dz = 1'b1;
            end
            OP_MFHI: res_c = hi_q;
            OP_MFLO: res_c = lo_q;
            default: res_c = '0;
        endcase
    end

    // Result, flag and HI/LO registers; held until the consumer takes them
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q        <= '0;
            lo_q        <= '0;
            c_q         <= '0;
            c_out_q     <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
            div_zero_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (iter_done && (state_q != ST_IDLE)) begin
            hi_q        <= eng_hi;
            lo_q        <= eng_lo;
            c_q         <= eng_lo;
            c_out_q     <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= (eng_lo == '0);
            div_zero_q  <= 1'b0;
            out_valid_q <= 1'b1;
        end else if (accept) begin
            if (start_iter) begin
                out_valid_q <= 1'b0;
            end else begin
                c_q         <= res_c;
                c_out_q     <= res_cout;
                overflow_q  <= res_ovf;
                zero_q      <= (res_c == '0);
                div_zero_q  <= res_dz;
                out_valid_q <= 1'b1;
                if (div_by_zero) begin
                    hi_q <= bus.a;
                    lo_q <= '1;
                end
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.busy      = busy;
    assign bus.out_valid = out_valid_q;
    assign bus.c         = c_q;
    assign bus.c_out     = c_out_q;
    assign bus.overflow  = overflow_q;
    assign bus.zero      = zero_q;
    assign bus.div_zero  = div_zero_q;

endmodule
